// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter
//   Shares one UDP TX path (header handshake plus AXI-Stream payload) between
//   NUM_PORTS requesters. Arbitration is round-robin and happens once per packet.
//   The winner's header is latched and offered downstream. Its payload is then
//   passed through until tlast, and the pointer moves past the winner.
//
// Ports
//   i_clk, i_reset        clock (rising edge), async active-high reset
//   s_hdr_*               per-port header request; field p lives at [W*p +: W]
//   s_axis_*              per-port payload stream
//   m_hdr_*               latched header towards UDP TX
//   m_axis_*              payload towards UDP TX (combinational pass-through)
//   o_busy                high whenever a packet is in flight
//   o_grant_id            port currently or most recently granted
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for any header valid; winner accepted combinationally
// S_HDR  | latched header offered on m_hdr_*, waiting for m_hdr_trdy
// S_DATA | payload of granted port passes through until a tlast beat
module udp_tx_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int AXI_DATA_WIDTH = 8,
  localparam int PORT_W        = $clog2(NUM_PORTS)
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic [NUM_PORTS-1:0]                s_hdr_tvalid,
  output logic [NUM_PORTS-1:0]                s_hdr_trdy,
  input  logic [16*NUM_PORTS-1:0]             s_hdr_src_port,
  input  logic [16*NUM_PORTS-1:0]             s_hdr_dst_port,
  input  logic [32*NUM_PORTS-1:0]             s_hdr_src_ip,
  input  logic [32*NUM_PORTS-1:0]             s_hdr_dst_ip,
  input  logic [8*NUM_PORTS-1:0]              s_hdr_protocol,
  input  logic [AXI_DATA_WIDTH*NUM_PORTS-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                s_axis_tlast,
  output logic [NUM_PORTS-1:0]                s_axis_trdy,
  output logic                                m_hdr_tvalid,
  input  logic                                m_hdr_trdy,
  output logic [15:0]                         m_hdr_src_port,
  output logic [15:0]                         m_hdr_dst_port,
  output logic [31:0]                         m_hdr_src_ip,
  output logic [31:0]                         m_hdr_dst_ip,
  output logic [7:0]                          m_hdr_protocol,
  output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_trdy,
  output logic                                o_busy,
  output logic [PORT_W-1:0]                   o_grant_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              state;
  logic [PORT_W-1:0]   rr_ptr;
  logic                win_valid;
  logic [PORT_W-1:0]   win_id;
  logic [PORT_W-1:0]   scan_idx;
  logic [PORT_W-1:0]   next_ptr;

  // base + off wrapped into 0..NUM_PORTS-1; works for non-power-of-two port counts
  function automatic logic [PORT_W-1:0] rr_idx(input logic [PORT_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return PORT_W'(sum);
  endfunction

  // first requester at or after rr_ptr
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = rr_idx(rr_ptr, i);
      if (!win_valid && s_hdr_tvalid[scan_idx]) begin
        win_valid = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  assign next_ptr = (o_grant_id == PORT_W'(NUM_PORTS - 1)) ? '0 : o_grant_id + 1'b1;

  // header ready is gated by i_reset as well, so a held reset never accepts a header
  always_comb begin
    s_hdr_trdy = '0;
    if (state == S_IDLE && win_valid && !i_reset) s_hdr_trdy[win_id] = 1'b1;
  end

  always_comb begin
    s_axis_trdy   = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    if (state == S_DATA) begin
      m_axis_tdata            = s_axis_tdata[AXI_DATA_WIDTH*o_grant_id +: AXI_DATA_WIDTH];
      m_axis_tvalid           = s_axis_tvalid[o_grant_id];
      m_axis_tlast            = s_axis_tlast[o_grant_id];
      s_axis_trdy[o_grant_id] = m_axis_trdy;
    end
  end

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      o_grant_id     <= '0;
      m_hdr_tvalid   <= 1'b0;
      m_hdr_src_port <= '0;
      m_hdr_dst_port <= '0;
      m_hdr_src_ip   <= '0;
      m_hdr_dst_ip   <= '0;
      m_hdr_protocol <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_valid) begin
            m_hdr_src_port <= s_hdr_src_port[16*win_id +: 16];
            m_hdr_dst_port <= s_hdr_dst_port[16*win_id +: 16];
            m_hdr_src_ip   <= s_hdr_src_ip[32*win_id +: 32];
            m_hdr_dst_ip   <= s_hdr_dst_ip[32*win_id +: 32];
            m_hdr_protocol <= s_hdr_protocol[8*win_id +: 8];
            o_grant_id     <= win_id;
            m_hdr_tvalid   <= 1'b1;
            state          <= S_HDR;
          end
        end
        S_HDR: begin
          if (m_hdr_tvalid && m_hdr_trdy) begin
            m_hdr_tvalid <= 1'b0;
            state        <= S_DATA;
          end
        end
        S_DATA: begin
          if (m_axis_tvalid && m_axis_trdy && m_axis_tlast) begin
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
module tb_udp_tx_arbiter;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int TO = 400;

  typedef struct {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  proto;
    int          len;
    int          gap;
    logic [7:0]  data [16];
  } pkt_t;

  logic              i_clk, i_reset;
  logic [NP-1:0]     s_hdr_tvalid, s_hdr_trdy;
  logic [16*NP-1:0]  s_hdr_src_port, s_hdr_dst_port;
  logic [32*NP-1:0]  s_hdr_src_ip, s_hdr_dst_ip;
  logic [8*NP-1:0]   s_hdr_protocol;
  logic [DW*NP-1:0]  s_axis_tdata;
  logic [NP-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_trdy;
  logic              m_hdr_tvalid, m_hdr_trdy;
  logic [15:0]       m_hdr_src_port, m_hdr_dst_port;
  logic [31:0]       m_hdr_src_ip, m_hdr_dst_ip;
  logic [7:0]        m_hdr_protocol;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tlast, m_axis_trdy;
  logic              o_busy;
  logic [1:0]        o_grant_id;

  udp_tx_arbiter #(.NUM_PORTS(NP), .AXI_DATA_WIDTH(DW)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_trdy(s_hdr_trdy),
    .s_hdr_src_port(s_hdr_src_port), .s_hdr_dst_port(s_hdr_dst_port),
    .s_hdr_src_ip(s_hdr_src_ip), .s_hdr_dst_ip(s_hdr_dst_ip),
    .s_hdr_protocol(s_hdr_protocol),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_trdy(s_axis_trdy),
    .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_trdy(m_hdr_trdy),
    .m_hdr_src_port(m_hdr_src_port), .m_hdr_dst_port(m_hdr_dst_port),
    .m_hdr_src_ip(m_hdr_src_ip), .m_hdr_dst_ip(m_hdr_dst_ip),
    .m_hdr_protocol(m_hdr_protocol),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_trdy(m_axis_trdy),
    .o_busy(o_busy), .o_grant_id(o_grant_id)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int   n_cmp, n_err;
  bit   mon_en;
  pkt_t pq [NP][$];
  pkt_t cur_pkt [NP];
  pkt_t exp_q [$];
  pkt_t cur;
  int   grant_log [$];
  int   exp_g [$];
  int   m_rr, last_win, beat_idx;
  bit   arb_open, hdr_done, hdr_next;
  int   hdr_stall, axis_mode, beat_gap_max, ports_done;
  bit   hdr_rand;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic pkt_t mk_pkt(input int len, input int gap);
    pkt_t pk;
    pk.src_port = 16'($urandom);
    pk.dst_port = 16'($urandom);
    pk.src_ip   = $urandom;
    pk.dst_ip   = $urandom;
    pk.proto    = 8'($urandom);
    pk.len      = len;
    pk.gap      = gap;
    for (int i = 0; i < 16; i++) pk.data[i] = 8'($urandom);
    return pk;
  endfunction

  task automatic set_hdr(input int p, input pkt_t pk);
    s_hdr_src_port[16*p +: 16] = pk.src_port;
    s_hdr_dst_port[16*p +: 16] = pk.dst_port;
    s_hdr_src_ip[32*p +: 32]   = pk.src_ip;
    s_hdr_dst_ip[32*p +: 32]   = pk.dst_ip;
    s_hdr_protocol[8*p +: 8]   = pk.proto;
  endtask

  // Reference: round-robin over the bench's own pending requests, one packet per grant,
  // packets delivered whole and in grant order.
  task automatic monitor();
    int win;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        m_rr = 0; last_win = 0; beat_idx = 0;
        arb_open = 1; hdr_done = 0; hdr_next = 0;
        exp_q.delete();
      end else if (mon_en) begin
        if (hdr_next) begin
          check("hdr_latency", 128'(m_hdr_tvalid), 128'(1));
          check("grant_id", 128'(o_grant_id), 128'(last_win));
          hdr_next = 0;
        end
        if (arb_open) begin
          check("busy_idle", 128'(o_busy), 128'(0));
          check("axis_idle", 128'({m_axis_tvalid, s_axis_trdy}), 128'(0));
          if (s_hdr_tvalid != '0) begin
            win = -1;
            for (int k = 0; k < NP; k++)
              if (win < 0 && s_hdr_tvalid[(m_rr + k) % NP]) win = (m_rr + k) % NP;
            check("hdr_trdy_grant", 128'(s_hdr_trdy), 128'(1) << win);
            exp_q.push_back(cur_pkt[win]);
            grant_log.push_back(win);
            last_win = win;
            m_rr = (win + 1) % NP;
            arb_open = 0; hdr_done = 0; hdr_next = 1; beat_idx = 0;
          end else begin
            check("hdr_trdy_idle", 128'(s_hdr_trdy), 128'(0));
            check("grant_hold", 128'(o_grant_id), 128'(last_win));
          end
        end else begin
          check("busy_active", 128'(o_busy), 128'(1));
          check("hdr_trdy_busy", 128'(s_hdr_trdy), 128'(0));
          if (!hdr_done) begin
            check("axis_in_hdr", 128'({m_axis_tvalid, s_axis_trdy}), 128'(0));
            if (m_hdr_tvalid && exp_q.size() > 0)
              check("hdr_fields",
                    128'({m_hdr_src_port, m_hdr_dst_port, m_hdr_src_ip, m_hdr_dst_ip, m_hdr_protocol}),
                    128'({exp_q[0].src_port, exp_q[0].dst_port, exp_q[0].src_ip, exp_q[0].dst_ip, exp_q[0].proto}));
            if (m_hdr_tvalid && m_hdr_trdy) begin
              if (exp_q.size() == 0) check("hdr_unexpected", 128'(1), 128'(0));
              else begin
                cur = exp_q.pop_front();
                hdr_done = 1;
              end
            end
          end else begin
            check("hdr_valid_in_data", 128'(m_hdr_tvalid), 128'(0));
            check("axis_trdy_route", 128'(s_axis_trdy), 128'(m_axis_trdy) << last_win);
            if (m_axis_tvalid && m_axis_trdy) begin
              check("beat_data", 128'(m_axis_tdata), 128'(cur.data[beat_idx % 16]));
              check("beat_last", 128'(m_axis_tlast), 128'(beat_idx == cur.len - 1));
              beat_idx++;
              if (m_axis_tlast || beat_idx >= cur.len) begin
                arb_open = 1;
                hdr_done = 0;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic trdy_proc();
    forever begin
      @(posedge i_clk);
      #1;
      if (hdr_stall > 0) begin
        m_hdr_trdy = 1'b0;
        if (m_hdr_tvalid) hdr_stall--;
      end else begin
        m_hdr_trdy = hdr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      case (axis_mode)
        1:       m_axis_trdy = ($urandom_range(0, 2) != 0);
        2:       m_axis_trdy = ~m_axis_trdy;
        default: m_axis_trdy = 1'b1;
      endcase
    end
  endtask

  // entered and left at posedge+1
  task automatic drive_port(input int p);
    pkt_t pk;
    int   t;
    while (pq[p].size() > 0) begin
      pk = pq[p].pop_front();
      cur_pkt[p] = pk;
      repeat (pk.gap) begin @(posedge i_clk); #1; end
      set_hdr(p, pk);
      s_hdr_tvalid[p] = 1'b1;
      t = 0;
      @(negedge i_clk);
      while (!s_hdr_trdy[p] && t < TO) begin t++; @(negedge i_clk); end
      if (!s_hdr_trdy[p]) check("hdr_wait_timeout", 128'(p), 128'(99));
      @(posedge i_clk); #1;
      s_hdr_tvalid[p] = 1'b0;
      if (t >= TO) continue;
      for (int b = 0; b < pk.len; b++) begin
        repeat ($urandom_range(0, beat_gap_max)) begin @(posedge i_clk); #1; end
        s_axis_tdata[DW*p +: DW] = pk.data[b];
        s_axis_tlast[p]  = (b == pk.len - 1);
        s_axis_tvalid[p] = 1'b1;
        t = 0;
        @(negedge i_clk);
        while (!s_axis_trdy[p] && t < TO) begin t++; @(negedge i_clk); end
        if (!s_axis_trdy[p]) check("beat_wait_timeout", 128'(p), 128'(99));
        @(posedge i_clk); #1;
        s_axis_tvalid[p] = 1'b0;
        s_axis_tlast[p]  = 1'b0;
        if (t >= TO) break;
      end
    end
  endtask

  task automatic run_phase(input string name);
    int t;
    ports_done = 0;
    for (int p = 0; p < NP; p++) begin
      automatic int pp = p;
      fork
        begin drive_port(pp); ports_done++; end
      join_none
    end
    t = 0;
    while (ports_done < NP && t < 20000) begin @(posedge i_clk); t++; end
    while (!(arb_open && exp_q.size() == 0) && t < 20000) begin @(posedge i_clk); t++; end
    if (t >= 20000) check({name, "_timeout"}, 128'(t), 128'(0));
    @(posedge i_clk); #1;
  endtask

  task automatic check_grants(input string name, input int start);
    check({name, "_count"}, 128'(grant_log.size() - start), 128'(exp_g.size()));
    for (int i = 0; i < exp_g.size(); i++)
      if (start + i < grant_log.size()) check(name, 128'(grant_log[start + i]), 128'(exp_g[i]));
  endtask

  initial begin
    pkt_t pk;
    int   gs;
    n_cmp = 0; n_err = 0;
    mon_en = 1; hdr_stall = 0; axis_mode = 0; beat_gap_max = 0; hdr_rand = 0;
    i_reset = 1'b1;
    s_hdr_tvalid = '1;
    s_hdr_src_port = '0; s_hdr_dst_port = '0; s_hdr_src_ip = '0; s_hdr_dst_ip = '0;
    s_hdr_protocol = '0; s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
    m_hdr_trdy = 1'b0; m_axis_trdy = 1'b0;
    fork
      monitor();
      trdy_proc();
    join_none

    @(negedge i_clk);
    check("rst_hdr_trdy", 128'(s_hdr_trdy), 128'(0));
    check("rst_outputs", 128'({m_hdr_tvalid, o_busy, o_grant_id, m_axis_tvalid, s_axis_trdy}), 128'(0));
    check("rst_fields", 128'({m_hdr_src_port, m_hdr_dst_port, m_hdr_src_ip, m_hdr_dst_ip, m_hdr_protocol}), 128'(0));
    s_hdr_tvalid = '0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    // ports 0 and 2 together from reset
    gs = grant_log.size();
    pq[0].push_back(mk_pkt(3, 0));
    pq[2].push_back(mk_pkt(5, 0));
    run_phase("two_ports");
    exp_g = {0, 2};
    check_grants("order_two_ports", gs);

    // port 0 alone, known source IP, 4-byte payload
    gs = grant_log.size();
    pk = mk_pkt(4, 0);
    pk.src_ip = 32'hC0A80001;
    pq[0].push_back(pk);
    run_phase("single");
    exp_g = {0};
    check_grants("order_single", gs);

    // single-beat packet followed back-to-back by pending requesters
    gs = grant_log.size();
    pq[1].push_back(mk_pkt(1, 0));
    pq[2].push_back(mk_pkt(4, 0));
    pq[3].push_back(mk_pkt(1, 0));
    run_phase("one_beat");
    exp_g = {1, 2, 3};
    check_grants("order_one_beat", gs);

    // all ports requesting continuously
    gs = grant_log.size();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++) pq[p].push_back(mk_pkt(3 + r, 0));
    run_phase("all_ports");
    exp_g = {0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    check_grants("order_all_ports", gs);

    // header stalled, then payload ready toggling; port 3 waits behind port 2
    gs = grant_log.size();
    hdr_stall = 5;
    axis_mode = 2;
    pq[2].push_back(mk_pkt(6, 0));
    pq[3].push_back(mk_pkt(3, 0));
    run_phase("stall");
    exp_g = {2, 3};
    check_grants("order_stall", gs);

    // random traffic
    hdr_rand = 1; axis_mode = 1; beat_gap_max = 2;
    for (int i = 0; i < 24; i++)
      pq[$urandom_range(0, NP - 1)].push_back(mk_pkt($urandom_range(1, 8), $urandom_range(0, 3)));
    run_phase("random");
    hdr_rand = 0; axis_mode = 0; beat_gap_max = 0;

    // leave the pointer at a non-zero value before the reset test
    gs = grant_log.size();
    pq[1].push_back(mk_pkt(2, 0));
    run_phase("pre_reset");
    exp_g = {1};
    check_grants("order_pre_reset", gs);

    // reset in the middle of a 10-byte payload
    repeat (2) begin @(posedge i_clk); #1; end
    mon_en = 0;
    pk = mk_pkt(10, 0);
    set_hdr(1, pk);
    s_hdr_tvalid[1] = 1'b1;
    @(negedge i_clk);
    check("mid_rst_grant", 128'(s_hdr_trdy), 128'(4'b0010));
    @(posedge i_clk); #1;
    s_hdr_tvalid[1] = 1'b0;
    @(negedge i_clk);
    check("mid_rst_hdr", 128'({m_hdr_tvalid, m_hdr_src_ip}), 128'({1'b1, pk.src_ip}));
    for (int b = 0; b < 3; b++) begin
      @(posedge i_clk); #1;
      s_axis_tdata[DW*1 +: DW] = pk.data[b];
      s_axis_tvalid[1] = 1'b1;
      if (b < 2) begin
        @(negedge i_clk);
        check("mid_rst_beat", 128'({m_axis_tvalid, m_axis_tdata, s_axis_trdy}),
              128'({1'b1, pk.data[b], 4'b0010}));
      end
    end
    #2 i_reset = 1'b1;
    #1;
    check("async_rst_busy", 128'({o_busy, m_hdr_tvalid, m_axis_tvalid}), 128'(0));
    check("async_rst_trdy", 128'({s_axis_trdy, s_hdr_trdy}), 128'(0));
    check("async_rst_state", 128'({o_grant_id, m_hdr_src_ip}), 128'(0));
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    mon_en = 1;

    // pointer must be back at 0: port 0 beats port 2
    gs = grant_log.size();
    pq[2].push_back(mk_pkt(3, 0));
    pq[0].push_back(mk_pkt(2, 0));
    run_phase("after_reset");
    exp_g = {0, 2};
    check_grants("order_after_reset", gs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
